// File: rtl/fsa_sprite_mover.sv
// Sprite mover: on each accepted frame tick, erases a WxH sprite, applies a
// clamped vertical move, then redraws it pixel-by-pixel from a bitmap mask.
// Emits absolute VGA coordinates, colour and write strobe directly.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_INIT_DRAW | paint the sprite at Y_INIT after reset (W*H writes)
// S_IDLE      | wait for draw_enable with exactly one of up/down
// S_ERASE     | paint BG_COLOUR over the sprite at the old row
// S_MOVE      | one quiet cycle, commit the latched target row
// S_DRAW      | paint the sprite from the mask at the new row
// S_DONE      | one-cycle done pulse, back to idle
module fsa_sprite_mover #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int SPRITE_W = 2,
  parameter int SPRITE_H = 3,
  parameter logic [SPRITE_W*SPRITE_H-1:0] SPRITE_MASK = 6'b001100,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter int X_POS = 4,
  parameter int Y_INIT = 60,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 117,
  parameter int STEP = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           draw_enable,
  input  logic           up,
  input  logic           down,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [2:0]     colour,
  output logic           write_en,
  output logic [Y_W-1:0] y_pos,
  output logic           busy,
  output logic           done
);

  localparam int PX_W  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int PY_W  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int IDX_W = (SPRITE_W * SPRITE_H > 1) ? $clog2(SPRITE_W * SPRITE_H) : 1;

  localparam logic [PX_W-1:0] PX_LAST  = PX_W'(SPRITE_W - 1);
  localparam logic [PY_W-1:0] PY_LAST  = PY_W'(SPRITE_H - 1);
  localparam logic [Y_W-1:0]  Y_INIT_L = Y_W'(Y_INIT);
  localparam logic [Y_W-1:0]  Y_MIN_L  = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0]  Y_MAX_L  = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0]  STEP_L   = Y_W'(STEP);

  typedef enum logic [2:0] {
    S_INIT_DRAW,
    S_IDLE,
    S_ERASE,
    S_MOVE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [PX_W-1:0] px_q;
  logic [PY_W-1:0] py_q;
  logic [Y_W-1:0]  y_pos_q;
  logic [Y_W-1:0]  target_q;
  logic [Y_W-1:0]  target_d;
  logic            accept;
  logic            last_px;
  logic            last_pix;
  logic [IDX_W-1:0] idx;
  logic            pixel_state;

  // Clamped target row; compares happen before the add/subtract so the
  // arithmetic can never wrap.
  always_comb begin
    target_d = y_pos_q;
    if (up) begin
      if ((y_pos_q > Y_MIN_L) && ((y_pos_q - Y_MIN_L) >= STEP_L)) target_d = y_pos_q - STEP_L;
      else                                                        target_d = Y_MIN_L;
    end else begin
      if ((y_pos_q < Y_MAX_L) && ((Y_MAX_L - y_pos_q) >= STEP_L)) target_d = y_pos_q + STEP_L;
      else                                                        target_d = Y_MAX_L;
    end
    accept   = draw_enable && (up ^ down) && (target_d != y_pos_q);
    last_px  = (px_q == PX_LAST);
    last_pix = last_px && (py_q == PY_LAST);
  end

  // Sequencer: state, pixel scan counters, sprite row and latched target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_INIT_DRAW;
      px_q     <= '0;
      py_q     <= '0;
      y_pos_q  <= Y_INIT_L;
      target_q <= Y_INIT_L;
    end else begin
      case (state_q)
        S_INIT_DRAW, S_ERASE, S_DRAW: begin
          if (last_px) begin
            px_q <= '0;
            py_q <= last_pix ? '0 : py_q + 1'b1;
          end else begin
            px_q <= px_q + 1'b1;
          end
          if (last_pix) state_q <= (state_q == S_ERASE) ? S_MOVE : S_DONE;
        end
        S_IDLE: begin
          if (accept) begin
            target_q <= target_d;
            state_q  <= S_ERASE;
          end
        end
        S_MOVE: begin
          y_pos_q <= target_q;
          state_q <= S_DRAW;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore output decode; write strobe is gated by reset so nothing is
  // written while reset is held even though the state decodes as a pass.
  always_comb begin
    idx         = IDX_W'(py_q) * IDX_W'(SPRITE_W) + IDX_W'(px_q);
    pixel_state = (state_q == S_INIT_DRAW) || (state_q == S_ERASE) || (state_q == S_DRAW);
    x_out       = X_W'(X_POS) + X_W'(px_q);
    y_out       = y_pos_q + Y_W'(py_q);
    colour      = BG_COLOUR;
    if (state_q != S_ERASE && SPRITE_MASK[idx]) colour = FG_COLOUR;
    write_en    = reset_n && pixel_state;
    y_pos       = y_pos_q;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_fsa_sprite_mover.sv
// Bench for fsa_sprite_mover: a pass-level model predicts every cycle's
// outputs, plus literal pixel/latency expectations for key scenarios.
module tb_fsa_sprite_mover;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       draw_enable = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [6:0] y_pos;
  logic [2:0] colour;
  logic       write_en;
  logic       busy;
  logic       done;

  fsa_sprite_mover dut (
    .clk(clk), .reset_n(reset_n), .draw_enable(draw_enable), .up(up), .down(down),
    .x_out(x_out), .y_out(y_out), .colour(colour), .write_en(write_en),
    .y_pos(y_pos), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit we; bit bz; bit dn; int x; int y; int c; int yp;} exp_t;
  typedef struct {int x; int y; int c;} pix_t;

  exp_t q[$];
  pix_t wlog[$];
  int   model_y = 60;
  int   done_cnt = 0;
  int   last_done_cyc = -1;
  logic [5:0] mask_v = 6'b001100;

  task automatic chk(string name, int act, int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // One full pixel pass: row-major, 2 wide x 3 high at column 4.
  task automatic push_pass(int yb, bit erase);
    exp_t e;
    for (int py = 0; py < 3; py++)
      for (int px = 0; px < 2; px++) begin
        e.we = 1; e.bz = 1; e.dn = 0;
        e.x = 4 + px; e.y = yb + py;
        e.c = erase ? 0 : (mask_v[py*2+px] ? 7 : 0);
        e.yp = yb;
        q.push_back(e);
      end
  endtask

  task automatic push_ctl(bit dn, int yp);
    exp_t e;
    e.we = 0; e.bz = 1; e.dn = dn; e.x = 0; e.y = 0; e.c = 0; e.yp = yp;
    q.push_back(e);
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    int tgt;
    logic [27:0] act, expv;
    if (!reset_n) begin
      chk("reset_state", int'({write_en, busy, done, y_pos}), int'({1'b0, 1'b1, 1'b0, 7'd60}));
      q.delete();
      model_y = 60;
      push_pass(60, 0);
      push_ctl(1, 60);
    end else begin
      if (q.size() > 0) e = q[0];
      else begin
        e.we = 0; e.bz = 0; e.dn = 0; e.x = 0; e.y = 0; e.c = 0; e.yp = model_y;
      end
      act  = {write_en, busy, done, y_pos,
              write_en ? x_out : 8'd0, write_en ? y_out : 7'd0, write_en ? colour : 3'd0};
      expv = {e.we, e.bz, e.dn, 7'(e.yp),
              e.we ? 8'(e.x) : 8'd0, e.we ? 7'(e.y) : 7'd0, e.we ? 3'(e.c) : 3'd0};
      n_vec++;
      if (act !== expv) begin
        n_err++;
        $display("FAIL cycle %0d outputs {we,busy,done,ypos,x,y,col}: got %h expected %h", cyc, act, expv);
      end
      if (write_en) wlog.push_back('{int'(x_out), int'(y_out), int'(colour)});
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (q.size() > 0) void'(q.pop_front());
      else if (draw_enable && (up ^ down)) begin
        tgt = up ? ((model_y - 1 < 0) ? 0 : model_y - 1) : ((model_y + 1 > 117) ? 117 : model_y + 1);
        if (tgt != model_y) begin
          push_pass(model_y, 1);
          push_ctl(0, model_y);
          push_pass(tgt, 0);
          push_ctl(1, tgt);
          model_y = tgt;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int acc_cyc;
  task automatic pulse(bit u, bit d, bit de);
    draw_enable = de; up = u; down = d;
    acc_cyc = cyc;
    step;
    draw_enable = 0; up = 0; down = 0;
  endtask

  task automatic wait_idle(string nm);
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      step;
    end
    chk(nm, int'(busy), 0);
  endtask

  function automatic int pk(int x, int y, int c);
    return x * 10000 + y * 10 + c;
  endfunction

  task automatic check_init_log(string nm);
    int ex[6] = '{4, 5, 4, 5, 4, 5};
    int ey[6] = '{60, 60, 61, 61, 62, 62};
    int ec[6] = '{0, 0, 7, 7, 0, 0};
    chk({nm, "_count"}, wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++)
      chk({nm, "_pixel"}, pk(wlog[i].x, wlog[i].y, wlog[i].c), pk(ex[i], ey[i], ec[i]));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rel_cyc, k, d0, w0;
    step; step;
    wlog.delete();
    reset_n = 1;
    rel_cyc = cyc;
    repeat (8) step;
    check_init_log("init");
    chk("init_ypos", int'(y_pos), 60);
    chk("init_done_lat", last_done_cyc - rel_cyc, 6);
    chk("init_done_cnt", done_cnt, 1);

    // single up move
    wlog.delete();
    pulse(1, 0, 1);
    k = acc_cyc;
    wait_idle("up_idle");
    chk("up_ypos", int'(y_pos), 59);
    chk("up_done_lat", last_done_cyc - k, 14);
    chk("up_count", wlog.size(), 12);
    if (wlog.size() == 12) begin
      chk("up_erase_first", pk(wlog[0].x, wlog[0].y, wlog[0].c), pk(4, 60, 0));
      chk("up_erase_last", pk(wlog[5].x, wlog[5].y, wlog[5].c), pk(5, 62, 0));
      chk("up_draw_fg", pk(wlog[8].x, wlog[8].y, wlog[8].c), pk(4, 60, 7));
      chk("up_draw_last", pk(wlog[11].x, wlog[11].y, wlog[11].c), pk(5, 61, 0));
    end

    // ignored requests
    d0 = done_cnt;
    pulse(1, 1, 1);
    repeat (3) step;
    pulse(1, 0, 0);
    repeat (3) step;
    pulse(0, 0, 1);
    repeat (3) step;
    chk("ignored_ypos", int'(y_pos), 59);
    chk("ignored_done", done_cnt, d0);

    // run to top limit and hold
    draw_enable = 1; up = 1;
    for (int i = 0; i < 2000; i++) begin
      if (y_pos == 0 && !busy) break;
      step;
    end
    chk("top_reached", int'(y_pos), 0);
    d0 = done_cnt; w0 = wlog.size();
    repeat (20) step;
    chk("top_hold_done", done_cnt, d0);
    chk("top_hold_writes", wlog.size(), w0);
    chk("top_hold_ypos", int'(y_pos), 0);
    up = 0;

    // run to bottom limit and hold
    down = 1;
    for (int i = 0; i < 2500; i++) begin
      if (y_pos == 117 && !busy) break;
      step;
    end
    chk("bot_reached", int'(y_pos), 117);
    d0 = done_cnt; w0 = wlog.size();
    repeat (20) step;
    chk("bot_hold_done", done_cnt, d0);
    chk("bot_hold_writes", wlog.size(), w0);
    chk("bot_hold_ypos", int'(y_pos), 117);
    draw_enable = 0; down = 0;
    step;

    // down pulsed mid-erase is dropped; after done it is accepted
    pulse(1, 0, 1);
    k = acc_cyc;
    step; step;
    pulse(0, 1, 1);
    wait_idle("mid_idle");
    chk("mid_ypos", int'(y_pos), 116);
    chk("mid_done_lat", last_done_cyc - k, 14);
    pulse(0, 1, 1);
    wait_idle("after_idle");
    chk("after_ypos", int'(y_pos), 117);

    // reset during draw pixel 3
    pulse(1, 0, 1);
    repeat (10) step;
    chk("draw_px3", int'({write_en, x_out, y_out, colour}), int'({1'b1, 8'd5, 7'd117, 3'd7}));
    reset_n = 0;
    #1;
    chk("abort_state", int'({write_en, y_pos}), int'({1'b0, 7'd60}));
    step; step;
    wlog.delete();
    d0 = done_cnt;
    reset_n = 1;
    rel_cyc = cyc;
    repeat (8) step;
    check_init_log("reinit");
    chk("reinit_ypos", int'(y_pos), 60);
    chk("reinit_done_cnt", done_cnt, d0 + 1);
    chk("reinit_done_lat", last_done_cyc - rel_cyc, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
